// File: rtl/mul_pkg.sv
// Shared definitions for the sequential shift-add multiplier: FSM encodings,
// default operand width and the matching iteration-counter width.
package mul_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_CNT_W = $clog2(DEF_WIDTH + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } mul_state_t;

endpackage

// File: rtl/mul_add_stage.sv
// Combinational WIDTH-bit ripple-carry adder (a, b, cin -> sum, cout), drop-in
// compatible with the other operand-path adders.
module mul_add_stage #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    logic [WIDTH:0] carry;

    assign carry[0] = cin;

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
        assign sum[gi]     = a[gi] ^ b[gi] ^ carry[gi];
        assign carry[gi+1] = (a[gi] & b[gi]) | (carry[gi] & (a[gi] ^ b[gi]));
    end

    assign cout = carry[WIDTH];

endmodule

// File: rtl/seq_shift_add_multiplier.sv
// Multi-cycle shift-add multiplier: one adder pass plus a right shift per cycle.
// Define SIGNED_MUL_EN to add the is_signed port (sign-magnitude signed multiply).
module seq_shift_add_multiplier
    import mul_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
`ifdef SIGNED_MUL_EN
    input  logic               is_signed,
`endif
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] product
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    mul_state_t          state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0]    acc_q, acc_d;
    logic [WIDTH-1:0]    mq_q, mq_d;
    logic [WIDTH-1:0]    mcand_q, mcand_d;
    logic [2*WIDTH-1:0]  product_q, product_d;
    logic                in_ready_q, in_ready_d;
    logic                out_valid_q, out_valid_d;

    logic [WIDTH-1:0]    a_load, b_load;
    logic [WIDTH-1:0]    add_b, add_sum;
    logic                add_cout;
    logic [WIDTH-1:0]    step_acc, step_mq;
    logic [2*WIDTH-1:0]  final_prod;

`ifdef SIGNED_MUL_EN
    logic neg_q, neg_d;
    logic a_neg, b_neg;

    // Signed operands are reduced to magnitudes; the most negative value maps
    // to 2^(WIDTH-1), which still fits the unsigned datapath.
    assign a_neg  = is_signed & a[WIDTH-1];
    assign b_neg  = is_signed & b[WIDTH-1];
    assign a_load = a_neg ? (~a + WIDTH'(1)) : a;
    assign b_load = b_neg ? (~b + WIDTH'(1)) : b;
    assign final_prod = neg_q ? (~{step_acc, step_mq} + (2*WIDTH)'(1))
                              : {step_acc, step_mq};
`else
    assign a_load     = a;
    assign b_load     = b;
    assign final_prod = {step_acc, step_mq};
`endif

    assign add_b = mq_q[0] ? mcand_q : '0;

    mul_add_stage #(
        .WIDTH (WIDTH)
    ) u_add (
        .a    (acc_q),
        .b    (add_b),
        .cin  (1'b0),
        .sum  (add_sum),
        .cout (add_cout)
    );

    // {cout, sum, mq} shifted right by one; the carry lands in acc's MSB.
    assign step_acc = {add_cout, add_sum[WIDTH-1:1]};
    assign step_mq  = {add_sum[0], mq_q[WIDTH-1:1]};

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        mq_d        = mq_q;
        mcand_d     = mcand_q;
        product_d   = product_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
`ifdef SIGNED_MUL_EN
        neg_d       = neg_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    state_d    = ST_BUSY;
                    cnt_d      = CNT_W'(WIDTH);
                    acc_d      = '0;
                    mq_d       = b_load;
                    mcand_d    = a_load;
                    in_ready_d = 1'b0;
`ifdef SIGNED_MUL_EN
                    neg_d      = a_neg ^ b_neg;
`endif
                end
            end
            ST_BUSY: begin
                acc_d = step_acc;
                mq_d  = step_mq;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d     = ST_DONE;
                    product_d   = final_prod;
                    out_valid_d = 1'b1;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d     = ST_IDLE;
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                in_ready_d  = 1'b1;
                out_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            acc_q       <= '0;
            mq_q        <= '0;
            mcand_q     <= '0;
            product_q   <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
`ifdef SIGNED_MUL_EN
            neg_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            mq_q        <= mq_d;
            mcand_q     <= mcand_d;
            product_q   <= product_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
`ifdef SIGNED_MUL_EN
            neg_q       <= neg_d;
`endif
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign product   = product_q;

endmodule

// File: tb/tb_seq_shift_add_multiplier.sv
// Self-checking bench for seq_shift_add_multiplier: directed corner cases plus
// random operands checked against a plain-arithmetic reference product.
module tb_seq_shift_add_multiplier;

    localparam int WIDTH = 32;

    logic               clk = 1'b0;
    logic               rst;
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic               is_signed;
    logic               out_valid;
    logic               out_ready;
    logic [2*WIDTH-1:0] product;

    int n_vectors    = 0;
    int n_checks     = 0;
    int miscompares  = 0;

    seq_shift_add_multiplier #(
        .WIDTH (WIDTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
`ifdef SIGNED_MUL_EN
        .is_signed (is_signed),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] ref_mul(input logic [31:0] av, input logic [31:0] bv,
                                            input logic sg);
        longint sa, sb;
        if (sg) begin
            sa = longint'($signed(av));
            sb = longint'($signed(bv));
            return 64'(sa * sb);
        end
        return {32'd0, av} * {32'd0, bv};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One full transaction; the accept edge counts as edge 1, so the product
    // should appear after edge WIDTH+1.
    task automatic do_op(input logic [31:0] av, input logic [31:0] bv, input logic sg,
                         input int hold, input bit junk);
        logic [63:0] expected;
        int edges;
        expected = ref_mul(av, bv, sg);
        @(negedge clk);
        check("in_ready_idle", 64'(in_ready), 64'd1);
        in_valid  = 1'b1;
        a         = av;
        b         = bv;
        is_signed = sg;
        @(negedge clk);
        edges = 1;
        if (!junk) in_valid = 1'b0;
        check("in_ready_busy", 64'(in_ready), 64'd0);
        while (out_valid !== 1'b1 && edges < 200) begin
            if (junk) begin
                a         = $urandom;
                b         = $urandom;
                is_signed = 1'($urandom);
            end
            @(negedge clk);
            edges++;
        end
        in_valid = 1'b0;
        check("latency", 64'(edges), 64'(WIDTH + 1));
        check("product", product, expected);
        check("in_ready_done", 64'(in_ready), 64'd0);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_valid", 64'(out_valid), 64'd1);
            check("hold_product", product, expected);
            check("hold_in_ready", 64'(in_ready), 64'd0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("drain_valid", 64'(out_valid), 64'd0);
        check("drain_in_ready", 64'(in_ready), 64'd1);
        check("kept_product", product, expected);
        n_vectors++;
        $display("op a=%h b=%h signed=%0d -> product=%h expected=%h latency=%0d",
                 av, bv, sg, product, expected, edges);
    endtask

    initial begin
        int seen_valid;
        rst       = 1'b1;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        is_signed = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_in_ready", 64'(in_ready), 64'd1);
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_product", product, 64'd0);
        rst = 1'b0;

        do_op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 0, 1'b0);
        check("max_const", product, 64'hFFFFFFFE_00000001);
        do_op(32'h12345678, 32'h00000000, 1'b0, 0, 1'b0);
        do_op(32'h00000000, 32'hFFFFFFFF, 1'b0, 1, 1'b0);
        do_op(32'h00000007, 32'h00000006, 1'b0, 5, 1'b0);
        check("seven_six", product, 64'h2A);

        // Abort mid-operation; product from the 7*6 run must be cleared.
        @(negedge clk);
        in_valid = 1'b1;
        a        = 32'hABCDEF01;
        b        = 32'h12345678;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_out_valid", 64'(out_valid), 64'd0);
        check("abort_product", product, 64'd0);
        check("abort_in_ready", 64'(in_ready), 64'd1);
        seen_valid = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid === 1'b1) seen_valid++;
        end
        check("abort_no_output", 64'(seen_valid), 64'd0);
        $display("abort test: out_valid pulses after reset=%0d", seen_valid);
        do_op(32'h00000007, 32'h00000006, 1'b0, 0, 1'b0);

        // Operands offered while busy must be ignored.
        do_op(32'hDEADBEEF, 32'h0BADF00D, 1'b0, 2, 1'b1);

`ifdef SIGNED_MUL_EN
        do_op(32'h80000000, 32'hFFFFFFFF, 1'b1, 0, 1'b0);
        check("signed_min", product, 64'h00000000_80000000);
        do_op(32'hFFFFFFFD, 32'h00000005, 1'b1, 0, 1'b0);
        check("signed_neg", product, 64'hFFFFFFFF_FFFFFFF1);
        do_op(32'hFFFFFFFD, 32'h00000005, 1'b0, 0, 1'b0);
        check("unsigned_same", product, 64'h00000004_FFFFFFF1);
        for (int i = 0; i < 6; i++) begin
            do_op($urandom, $urandom, 1'b1, int'($urandom_range(0, 2)), 1'b0);
        end
`endif

        for (int i = 0; i < 16; i++) begin
            do_op($urandom, $urandom, 1'b0, int'($urandom_range(0, 3)), bit'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, miscompares);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
